cla_sub_seq: RTL and testbench

//   Multi-cycle wide subtractor: Diff = A - B - Bin over WIDTH bits, processed 4 bits/cycle

---
 rtl/cla_sub_seq.sv | 147 ++++++++++++++
 tb/tb_cla_sub_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cla_sub_seq.sv
// Sequential wide subtractor: A - B - Bin computed 4 bits per cycle as A + ~B + ~Bin
// through one 4-bit carry-lookahead slice, with valid/ready handshakes on both sides.
module cla_sub_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             BorrowOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int SLICES = WIDTH / 4;
  localparam int CNT_W  = $clog2(SLICES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // 4-bit carry-lookahead slice; returns {carry_out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a | b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], a ^ b ^ c[3:0]};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [4:0]       slice;
  logic [WIDTH-1:0] res_new;

  assign slice   = cla4(a_q[3:0], nb_q[3:0], carry_q);
  // New sum nibble enters at the top; after the last slice the register holds the full result.
  assign res_new = WIDTH'({slice[3:0], res_q} >> 4);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    nb_d     = nb_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          nb_d    = ~B;
          carry_d = ~Bin;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        res_d   = res_new;
        a_d     = a_q >> 4;
        nb_d    = nb_q >> 4;
        carry_d = slice[4];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SLICES - 1)) begin
          state_d  = S_DONE;
          diff_d   = res_new;
          borrow_d = ~slice[4];
          ovf_d    = (a_msb_q != b_msb_q) && (res_new[WIDTH-1] != a_msb_q);
          zero_d   = (res_new == '0);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      nb_q     <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign Diff      = diff_q;
  assign BorrowOut = borrow_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_cla_sub_seq.sv
// Bench for cla_sub_seq (WIDTH=16): vector table plus scoreboard queue, with
// hand-written sequences for output hold under backpressure and mid-operation reset.
module tb_cla_sub_seq;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic             Bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] Diff;
  logic             BorrowOut;
  logic             Overflow;
  logic             Zero;

  always #5 clk = ~clk;

  cla_sub_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .BorrowOut(BorrowOut), .Overflow(Overflow), .Zero(Zero)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t sb_q[$];
  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] full;
    vec_t v;
    full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    v.a    = a;
    v.b    = b;
    v.bin  = bin;
    v.diff = full[15:0];
    v.bo   = full[16];
    v.ov   = (a[15] != b[15]) && (full[15] != a[15]);
    v.z    = (full[15:0] == 16'd0);
    return v;
  endfunction

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic bin,
                              input logic [15:0] d, input logic bo, input logic ov, input logic z);
    vec_t v;
    v.a = a; v.b = b; v.bin = bin; v.diff = d; v.bo = bo; v.ov = ov; v.z = z;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input vec_t v, input bit early_ready, input bit hold_test);
    int   lat;
    vec_t e;
    @(negedge clk);
    A = v.a; B = v.b; Bin = v.bin; in_valid = 1'b1; out_ready = early_ready;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(v);
    #1;
    in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    chk("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got 0 expected 1 within 20 cycles");
      sb_q.delete();
      out_ready = 1'b0;
      return;
    end
    chk("latency", 32'(lat), 32'd4);
    e = sb_q.pop_front();
    chk("diff", 32'(Diff), 32'(e.diff));
    chk("borrow", 32'(BorrowOut), 32'(e.bo));
    chk("overflow", 32'(Overflow), 32'(e.ov));
    chk("zero", 32'(Zero), 32'(e.z));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    if (!early_ready) begin
      if (hold_test) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
          @(posedge clk);
          #1;
          chk("hold_out_valid", 32'(out_valid), 32'd1);
          chk("hold_in_ready", 32'(in_ready), 32'd0);
          chk("hold_diff", 32'(Diff), 32'(e.diff));
          chk("hold_borrow", 32'(BorrowOut), 32'(e.bo));
        end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_diff_kept", 32'(Diff), 32'(e.diff));
    out_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = mk(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tbl[3] = mk(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    tbl[4] = mk(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[5] = mk(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    tbl[6] = mk(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    tbl[7] = mk(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    tbl[8] = mk(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

    // reset state
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_flags", {29'd0, BorrowOut, Overflow, Zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(tbl[i], 1'b0, 1'b0);

    for (int i = 0; i < 6; i++)
      run_op(model(16'($urandom), 16'($urandom), 1'($urandom)), (i % 2) == 1, 1'b0);

    // backpressure in DONE with operands offered: results must hold, nothing captured
    run_op(mk(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1);

    // abort after two BUSY cycles
    @(negedge clk);
    A = 16'h4321; B = 16'h0021; Bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_diff", 32'(Diff), 32'd0);
    chk("abort_flags", {29'd0, BorrowOut, Overflow, Zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(mk(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
